// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access arbiter: access sizes, FSM states, owners.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BAD  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef enum logic {
        OwnCpu,
        OwnDbg
    } owner_e;

    // Bytes touched by an access; the invalid encoding is rejected separately.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_req_checker.sv
// Combinational fault decode for one requester: invalid size, misalignment, or a byte past the
// end of data memory.
module dmem_req_checker
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_LEN      = 32,
    parameter int unsigned DATA_MEM_SIZE = 16
) (
    input  logic [1:0]          size,
    input  logic [WORD_LEN-1:0] addr,
    output logic                fault
);

    localparam int unsigned AW = WORD_LEN + 1;

    logic [AW-1:0] last_byte;
    logic          misaligned;
    logic          out_of_range;

    always_comb begin
        // One extra bit so an access near the top of the address space cannot wrap to 0.
        last_byte    = {1'b0, addr} + AW'(size_bytes(size)) - AW'(1);
        out_of_range = (last_byte >= AW'(DATA_MEM_SIZE));
        misaligned   = ((size == SZ_HALF) && addr[0]) ||
                       ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        fault        = (size == SZ_BAD) || misaligned || out_of_range;
    end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and the debug unit.
// Fixed CPU priority with a starvation guard; faulting requests complete without an access.
module dmem_access_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned WORD_LEN      = 32,
    parameter int unsigned DATA_MEM_SIZE = 16,
    parameter int unsigned DBG_MAX_WAIT  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,

    input  logic                i_cpu_req,
    input  logic                i_cpu_we,
    input  logic [1:0]          i_cpu_size,
    input  logic                i_cpu_unsigned,
    input  logic [WORD_LEN-1:0] i_cpu_addr,
    input  logic [WORD_LEN-1:0] i_cpu_wdata,
    output logic                o_cpu_gnt,
    output logic                o_cpu_rvalid,
    output logic                o_cpu_err,
    output logic [WORD_LEN-1:0] o_cpu_rdata,

    input  logic                i_dbg_req,
    input  logic                i_dbg_we,
    input  logic [WORD_LEN-1:0] i_dbg_addr,
    input  logic [WORD_LEN-1:0] i_dbg_wdata,
    output logic                o_dbg_gnt,
    output logic                o_dbg_rvalid,
    output logic                o_dbg_err,
    output logic [WORD_LEN-1:0] o_dbg_rdata,

    output logic                o_mem_step,
    output logic                o_mem_we,
    output logic [1:0]          o_mem_size,
    output logic                o_mem_unsigned,
    output logic [WORD_LEN-1:0] o_mem_addr,
    output logic [WORD_LEN-1:0] o_mem_wdata,
    input  logic [WORD_LEN-1:0] i_mem_rdata
);

    localparam int unsigned     WaitW   = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(DBG_MAX_WAIT);

    state_e           state_q;
    owner_e           owner_q;
    logic [WaitW-1:0] wait_q;

    logic cpu_fault;
    logic dbg_fault;
    logic arb_phase;
    logic cpu_gnt;
    logic dbg_gnt;
    logic req_fault;

    dmem_req_checker #(
        .WORD_LEN      (WORD_LEN),
        .DATA_MEM_SIZE (DATA_MEM_SIZE)
    ) u_cpu_check (
        .size  (i_cpu_size),
        .addr  (i_cpu_addr),
        .fault (cpu_fault)
    );

    dmem_req_checker #(
        .WORD_LEN      (WORD_LEN),
        .DATA_MEM_SIZE (DATA_MEM_SIZE)
    ) u_dbg_check (
        .size  (SZ_WORD),
        .addr  (i_dbg_addr),
        .fault (dbg_fault)
    );

    always_comb begin
        // Grants are held off during reset so every output reads 0 while i_rst is low.
        arb_phase = i_rst && ((state_q == StIdle) || (state_q == StResp));
        cpu_gnt   = arb_phase && i_cpu_req && !(i_dbg_req && (wait_q == WaitMax));
        dbg_gnt   = arb_phase && i_dbg_req && !cpu_gnt;
        req_fault = dbg_gnt ? dbg_fault : cpu_fault;
    end

    assign o_cpu_gnt = cpu_gnt;
    assign o_dbg_gnt = dbg_gnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= StIdle;
            owner_q        <= OwnCpu;
            wait_q         <= '0;
            o_cpu_rvalid   <= 1'b0;
            o_cpu_err      <= 1'b0;
            o_cpu_rdata    <= '0;
            o_dbg_rvalid   <= 1'b0;
            o_dbg_err      <= 1'b0;
            o_dbg_rdata    <= '0;
            o_mem_step     <= 1'b0;
            o_mem_we       <= 1'b0;
            o_mem_size     <= '0;
            o_mem_unsigned <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
        end else begin
            o_cpu_rvalid <= 1'b0;
            o_cpu_err    <= 1'b0;
            o_dbg_rvalid <= 1'b0;
            o_dbg_err    <= 1'b0;

            // Counts arbitration rounds debug has lost; ACCESS cycles hold the count.
            if (!i_dbg_req || dbg_gnt) begin
                wait_q <= '0;
            end else if (arb_phase && (wait_q != WaitMax)) begin
                wait_q <= wait_q + WaitW'(1);
            end

            unique case (state_q)
                StAccess: begin
                    state_q    <= StResp;
                    o_mem_step <= 1'b0;
                    o_mem_we   <= 1'b0;
                    if (owner_q == OwnDbg) begin
                        o_dbg_rvalid <= 1'b1;
                        o_dbg_rdata  <= o_mem_we ? '0 : i_mem_rdata;
                    end else begin
                        o_cpu_rvalid <= 1'b1;
                        o_cpu_rdata  <= o_mem_we ? '0 : i_mem_rdata;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    if (cpu_gnt || dbg_gnt) begin
                        owner_q        <= dbg_gnt ? OwnDbg : OwnCpu;
                        o_mem_size     <= dbg_gnt ? SZ_WORD : i_cpu_size;
                        o_mem_unsigned <= dbg_gnt ? 1'b0 : i_cpu_unsigned;
                        o_mem_addr     <= dbg_gnt ? i_dbg_addr : i_cpu_addr;
                        o_mem_wdata    <= dbg_gnt ? i_dbg_wdata : i_cpu_wdata;
                        if (req_fault) begin
                            state_q <= StResp;
                            if (dbg_gnt) begin
                                o_dbg_rvalid <= 1'b1;
                                o_dbg_err    <= 1'b1;
                                o_dbg_rdata  <= '0;
                            end else begin
                                o_cpu_rvalid <= 1'b1;
                                o_cpu_err    <= 1'b1;
                                o_cpu_rdata  <= '0;
                            end
                        end else begin
                            state_q    <= StAccess;
                            o_mem_step <= 1'b1;
                            o_mem_we   <= dbg_gnt ? i_dbg_we : i_cpu_we;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: big-endian byte memory model, vector table of CPU accesses,
// and hand sequences for starvation, debug access and reset during an access.
module tb_dmem_access_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cpu_req, i_cpu_we, i_cpu_unsigned;
    logic [1:0]  i_cpu_size;
    logic [31:0] i_cpu_addr, i_cpu_wdata;
    logic        o_cpu_gnt, o_cpu_rvalid, o_cpu_err;
    logic [31:0] o_cpu_rdata;
    logic        i_dbg_req, i_dbg_we;
    logic [31:0] i_dbg_addr, i_dbg_wdata;
    logic        o_dbg_gnt, o_dbg_rvalid, o_dbg_err;
    logic [31:0] o_dbg_rdata;
    logic        o_mem_step, o_mem_we, o_mem_unsigned;
    logic [1:0]  o_mem_size;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [31:0] i_mem_rdata = 32'h0;

    always #5 i_clk = ~i_clk;

    dmem_access_arbiter #(
        .WORD_LEN      (32),
        .DATA_MEM_SIZE (16),
        .DBG_MAX_WAIT  (2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cpu_req      (i_cpu_req),
        .i_cpu_we       (i_cpu_we),
        .i_cpu_size     (i_cpu_size),
        .i_cpu_unsigned (i_cpu_unsigned),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_wdata    (i_cpu_wdata),
        .o_cpu_gnt      (o_cpu_gnt),
        .o_cpu_rvalid   (o_cpu_rvalid),
        .o_cpu_err      (o_cpu_err),
        .o_cpu_rdata    (o_cpu_rdata),
        .i_dbg_req      (i_dbg_req),
        .i_dbg_we       (i_dbg_we),
        .i_dbg_addr     (i_dbg_addr),
        .i_dbg_wdata    (i_dbg_wdata),
        .o_dbg_gnt      (o_dbg_gnt),
        .o_dbg_rvalid   (o_dbg_rvalid),
        .o_dbg_err      (o_dbg_err),
        .o_dbg_rdata    (o_dbg_rdata),
        .o_mem_step     (o_mem_step),
        .o_mem_we       (o_mem_we),
        .o_mem_size     (o_mem_size),
        .o_mem_unsigned (o_mem_unsigned),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata)
    );

    // Memory model: acts on the falling edge, big-endian byte order.
    logic [7:0] mem [16];
    bit         mem_init = 1'b0;
    int         we_cnt = 0;
    logic [3:0] ma;

    function automatic logic [31:0] mem_read(input logic [3:0] a, input logic [1:0] sz,
                                             input logic uns);
        logic [31:0] r;
        case (sz)
            2'b00:   r = uns ? {24'h0, mem[a]} : {{24{mem[a][7]}}, mem[a]};
            2'b01:   r = uns ? {16'h0, mem[a], mem[a+4'd1]}
                             : {{16{mem[a][7]}}, mem[a], mem[a+4'd1]};
            default: r = {mem[a], mem[a+4'd1], mem[a+4'd2], mem[a+4'd3]};
        endcase
        return r;
    endfunction

    always @(negedge i_clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'h00;
            mem[2]  <= 8'h80;
            mem[4]  <= 8'h11; mem[5]  <= 8'h22; mem[6]  <= 8'h33; mem[7]  <= 8'h44;
            mem[8]  <= 8'hde; mem[9]  <= 8'had; mem[10] <= 8'hbe; mem[11] <= 8'hef;
            mem[15] <= 8'ha5;
            mem_init <= 1'b1;
        end else if (o_mem_step) begin
            ma = o_mem_addr[3:0];
            if (o_mem_we) begin
                we_cnt <= we_cnt + 1;
                case (o_mem_size)
                    2'b00: mem[ma] <= o_mem_wdata[7:0];
                    2'b01: begin
                        mem[ma]      <= o_mem_wdata[15:8];
                        mem[ma+4'd1] <= o_mem_wdata[7:0];
                    end
                    default: begin
                        mem[ma]      <= o_mem_wdata[31:24];
                        mem[ma+4'd1] <= o_mem_wdata[23:16];
                        mem[ma+4'd2] <= o_mem_wdata[15:8];
                        mem[ma+4'd3] <= o_mem_wdata[7:0];
                    end
                endcase
            end else begin
                i_mem_rdata <= mem_read(ma, o_mem_size, o_mem_unsigned);
            end
        end
    end

    typedef struct {
        string       name;
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        string       name;
        bit          own;
        bit          err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   s_cyc;
    bit   s_cpu_gnt, s_dbg_gnt, s_step;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void add(input string name, input bit we, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input bit err, input logic [31:0] rdata);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.err = err; v.rdata = rdata;
        vecs.push_back(v);
    endfunction

    function automatic void check_resp(input bit own, input logic err, input logic [31:0] rdata);
        exp_t e;
        if (sb.size() == 0) begin
            chk(own ? "dbg_spurious_rvalid" : "cpu_spurious_rvalid", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.name, "_owner"}, 32'(own), 32'(e.own));
        chk({e.name, "_err"}, 32'(err), 32'(e.err));
        chk({e.name, "_rdata"}, rdata, e.rdata);
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
    endfunction

    // Samples the current cycle at the falling edge, then moves to just after the next rise.
    task automatic tick();
        @(negedge i_clk);
        cyc++;
        s_cyc     = cyc;
        s_cpu_gnt = o_cpu_gnt;
        s_dbg_gnt = o_dbg_gnt;
        s_step    = o_mem_step;
        chk("gnt_exclusive", 32'(o_cpu_gnt & o_dbg_gnt), 32'd0);
        chk("gnt_in_access", 32'((o_cpu_gnt | o_dbg_gnt) & o_mem_step), 32'd0);
        if (o_cpu_rvalid) check_resp(1'b0, o_cpu_err, o_cpu_rdata);
        if (o_dbg_rvalid) check_resp(1'b1, o_dbg_err, o_dbg_rdata);
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic push_exp(input string name, input bit own, input bit err,
                            input logic [31:0] rdata, input int due);
        exp_t e;
        e.name = name; e.own = own; e.err = err; e.rdata = rdata; e.due = due;
        sb.push_back(e);
    endtask

    task automatic txn(input bit own, input vec_t v);
        int n = 0;
        int we0;
        bit g;
        if (own) begin
            i_dbg_req = 1'b1; i_dbg_we = v.we; i_dbg_addr = v.addr; i_dbg_wdata = v.wdata;
        end else begin
            i_cpu_req = 1'b1; i_cpu_we = v.we; i_cpu_size = v.size; i_cpu_unsigned = v.uns;
            i_cpu_addr = v.addr; i_cpu_wdata = v.wdata;
        end
        we0 = we_cnt;
        do begin
            tick();
            n++;
            g = own ? s_dbg_gnt : s_cpu_gnt;
        end while (!g && n < 20);
        i_cpu_req = 1'b0;
        i_dbg_req = 1'b0;
        if (!g) begin
            chk({v.name, "_gnt"}, 32'd0, 32'd1);
            return;
        end
        push_exp(v.name, own, v.err, v.rdata, s_cyc + (v.err ? 1 : 2));
        tick();
        chk({v.name, "_step"}, 32'(s_step), 32'(!v.err));
        drain();
        if (v.err) chk({v.name, "_no_write"}, 32'(we_cnt - we0), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit [5:0] exp_cg = 6'b000101;
        bit [5:0] exp_dg = 6'b010000;
        vec_t     dv;
        int       n;

        i_rst = 1'b0;
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_size = 2'b11; i_cpu_unsigned = 1'b0;
        i_cpu_addr = 32'h4; i_cpu_wdata = 32'h0;
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 32'h8; i_dbg_wdata = 32'h0;

        //  name        we  size   uns addr          wdata         err rdata
        add("ld_w4",    0, 2'b11, 0, 32'h4,        32'h0,        0, 32'h11223344);
        add("st_h3",    1, 2'b01, 0, 32'h3,        32'h0000beef, 1, 32'h0);
        add("ld_w14",   0, 2'b11, 0, 32'he,        32'h0,        1, 32'h0);
        add("ld_b15",   0, 2'b00, 0, 32'hf,        32'h0,        0, 32'hffffffa5);
        add("ld_bff",   0, 2'b00, 0, 32'hff,       32'h0,        1, 32'h0);
        add("ld_b2s",   0, 2'b00, 0, 32'h2,        32'h0,        0, 32'hffffff80);
        add("ld_b2u",   0, 2'b00, 1, 32'h2,        32'h0,        0, 32'h00000080);
        add("sz_bad",   0, 2'b10, 0, 32'h0,        32'h0,        1, 32'h0);
        add("st_w12",   1, 2'b11, 0, 32'hc,        32'h01020304, 0, 32'h0);
        add("ld_h12u",  0, 2'b01, 1, 32'hc,        32'h0,        0, 32'h00000102);
        add("st_b14",   1, 2'b00, 0, 32'he,        32'h123456f0, 0, 32'h0);
        add("ld_h14s",  0, 2'b01, 0, 32'he,        32'h0,        0, 32'hfffff004);
        add("ld_h14u",  0, 2'b01, 1, 32'he,        32'h0,        0, 32'h0000f004);
        add("ld_w13",   0, 2'b11, 0, 32'hd,        32'h0,        1, 32'h0);
        add("ld_h1",    0, 2'b01, 0, 32'h1,        32'h0,        1, 32'h0);
        add("st_b16",   1, 2'b00, 0, 32'h10,       32'h0,        1, 32'h0);
        add("ld_w12",   0, 2'b11, 0, 32'hc,        32'h0,        0, 32'h0102f004);
        add("ld_wtop",  0, 2'b11, 0, 32'hfffffffc, 32'h0,        1, 32'h0);
        add("ld_w0",    0, 2'b11, 0, 32'h0,        32'h0,        0, 32'h00008000);

        // Reset: requests are held high but nothing may be granted or driven.
        repeat (2) tick();
        chk("rst_cpu_gnt", 32'(o_cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(o_dbg_gnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(o_cpu_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(o_dbg_rvalid), 32'd0);
        chk("rst_mem_step", 32'(o_mem_step), 32'd0);
        chk("rst_mem_we", 32'(o_mem_we), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_cpu_rdata", o_cpu_rdata, 32'd0);
        i_cpu_req = 1'b0;
        i_dbg_req = 1'b0;
        i_rst = 1'b1;
        tick();

        foreach (vecs[i]) txn(1'b0, vecs[i]);
        chk("st_h3_mem_kept", {8'h0, mem[2], mem[3], mem[4]}, 32'h00800011);

        add("dbg_ld_w2", 0, 2'b11, 0, 32'h2, 32'h0, 1, 32'h0);
        add("dbg_ld_w4", 0, 2'b11, 0, 32'h4, 32'h0, 0, 32'h11223344);
        txn(1'b1, vecs[vecs.size()-2]);
        txn(1'b1, vecs[vecs.size()-1]);

        // Starvation guard: CPU requests continuously, debug from the same cycle.
        i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_size = 2'b11; i_cpu_unsigned = 1'b0;
        i_cpu_addr = 32'h4;
        i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 32'h8;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("starve_cpu_gnt_c%0d", c), 32'(s_cpu_gnt), 32'(exp_cg[c]));
            chk($sformatf("starve_dbg_gnt_c%0d", c), 32'(s_dbg_gnt), 32'(exp_dg[c]));
            if (s_cpu_gnt) push_exp("starve_cpu", 1'b0, 1'b0, 32'h11223344, s_cyc + 2);
            if (s_dbg_gnt) push_exp("starve_dbg", 1'b1, 1'b0, 32'hdeadbeef, s_cyc + 2);
            if (c == 4) begin
                i_cpu_req = 1'b0;
                i_dbg_req = 1'b0;
            end
        end
        drain();

        // Reset while a granted store is in its ACCESS cycle.
        i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_size = 2'b11; i_cpu_addr = 32'h8;
        i_cpu_wdata = 32'hcafef00d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_cpu_gnt && n < 20);
        chk("rst_st_gnt", 32'(s_cpu_gnt), 32'd1);
        i_cpu_req = 1'b0;
        chk("rst_st_pre_we", 32'(o_mem_we), 32'd1);
        chk("rst_st_pre_step", 32'(o_mem_step), 32'd1);
        i_rst = 1'b0;
        #1;
        chk("rst_st_we_drop", 32'(o_mem_we), 32'd0);
        chk("rst_st_step_drop", 32'(o_mem_step), 32'd0);
        repeat (2) tick();
        i_rst = 1'b1;
        repeat (2) tick();
        chk("rst_st_mem_kept", {mem[8], mem[9], mem[10], mem[11]}, 32'hdeadbeef);
        dv.name = "dbg_rb8"; dv.we = 1'b0; dv.size = 2'b11; dv.uns = 1'b0; dv.addr = 32'h8;
        dv.wdata = 32'h0; dv.err = 1'b0; dv.rdata = 32'hdeadbeef;
        txn(1'b1, dv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
